// File: rtl/nabp_image_ram_arbiter.sv
// Image RAM port arbiter for the back-projection processing elements.
// Round-robin grants one PE pixel write per cycle and pushes it through a
// three-stage read-modify-write pipeline (S1 read, S2 combine, write register).
// Accumulate mode forwards in-flight results so back-to-back hits on one
// address sum correctly. A small IDLE/RUN/DRAIN sequencer reports frame done.
module nabp_image_ram_arbiter #(
    parameter int NUM_PE = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int ACC_W  = 24
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_frame_start,
    input  logic                     i_frame_end,
    input  logic                     i_cfg_accumulate,
    input  logic [NUM_PE-1:0]        i_pe_valid,
    input  logic [NUM_PE*ADDR_W-1:0] i_pe_addr,
    input  logic [NUM_PE*DATA_W-1:0] i_pe_val,
    output logic [NUM_PE-1:0]        o_pe_ready,
    output logic                     o_im_rd_en,
    output logic [ADDR_W-1:0]        o_im_rd_addr,
    input  logic [ACC_W-1:0]         i_im_rd_data,
    output logic                     o_im_wr_en,
    output logic [ADDR_W-1:0]        o_im_wr_addr,
    output logic [ACC_W-1:0]         o_im_wr_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_sat
);

    localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_mode;
    logic               r_sat;
    logic               r_done;
    logic [PTR_W-1:0]   r_rr;

    // Pipeline stages: S1 (RAM read issued), S2 (combine), write register,
    // and a hold copy of the write issued one cycle earlier.
    logic               r_s1_valid;
    logic [ADDR_W-1:0]  r_s1_addr;
    logic [DATA_W-1:0]  r_s1_val;
    logic               r_s2_valid;
    logic [ADDR_W-1:0]  r_s2_addr;
    logic [DATA_W-1:0]  r_s2_val;
    logic               r_wr_valid;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [ACC_W-1:0]   r_wr_data;
    logic               r_hold_valid;
    logic [ADDR_W-1:0]  r_hold_addr;
    logic [ACC_W-1:0]   r_hold_data;

    logic               w_accept;
    logic [PTR_W-1:0]   w_grant_idx;
    logic [PTR_W-1:0]   w_cand;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_val;
    logic [ACC_W-1:0]   w_base;
    logic [ACC_W-1:0]   w_val_ext;
    logic [ACC_W:0]     w_sum;
    logic               w_ovf;
    logic [ACC_W-1:0]   w_result;
    logic               w_clamp;
    logic               w_pipe_empty_next;

    // Round-robin search from r_rr upward; only RUN grants.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_accept    = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        if (r_state == S_RUN) begin
            for (int k = 0; k < NUM_PE; k++) begin
                w_cand = PTR_W'((int'(r_rr) + k) % NUM_PE);
                if (!w_accept && i_pe_valid[w_cand]) begin
                    w_accept    = 1'b1;
                    w_grant_idx = w_cand;
                end
            end
        end
    end

    assign o_pe_ready = w_accept ? (NUM_PE'(1) << w_grant_idx) : '0;
    assign w_sel_addr = i_pe_addr[w_grant_idx*ADDR_W +: ADDR_W];
    assign w_sel_val  = i_pe_val[w_grant_idx*DATA_W +: DATA_W];

    // S2 combine: pick the freshest copy of the word, then add and clamp.
    always_comb begin
        w_base = i_im_rd_data;
        if (r_wr_valid && (r_wr_addr == r_s2_addr)) begin
            w_base = r_wr_data;
        end else if (r_hold_valid && (r_hold_addr == r_s2_addr)) begin
            w_base = r_hold_data;
        end
        w_val_ext = {{(ACC_W-DATA_W){r_s2_val[DATA_W-1]}}, r_s2_val};
        w_sum     = {w_base[ACC_W-1], w_base} + {w_val_ext[ACC_W-1], w_val_ext};
        w_ovf     = (w_sum[ACC_W] != w_sum[ACC_W-1]);
        w_clamp   = r_mode && r_s2_valid && w_ovf;
        if (!r_mode) begin
            w_result = w_val_ext;
        end else if (w_ovf) begin
            w_result = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            w_result = w_sum[ACC_W-1:0];
        end
    end

    // Frame sequencer next-state decode.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (i_frame_start) w_next_state = S_RUN;
            S_RUN:   if (i_frame_end)   w_next_state = S_DRAIN;
            S_DRAIN: if (!r_s1_valid && !r_s2_valid && !r_wr_valid) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Pipeline will hold nothing next cycle, so DRAIN leaves then.
    assign w_pipe_empty_next = !w_accept && !r_s1_valid && !r_s2_valid;

    // Sequencer state and per-frame control registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_sat   <= 1'b0;
            r_done  <= 1'b0;
            r_rr    <= '0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (w_next_state == S_DRAIN) && w_pipe_empty_next;
            if (r_state == S_IDLE && i_frame_start) begin
                r_mode <= i_cfg_accumulate;
                r_sat  <= 1'b0;
            end else if (w_clamp) begin
                r_sat  <= 1'b1;
            end
            if (w_accept) begin
                r_rr <= (w_grant_idx == PTR_W'(NUM_PE-1)) ? '0 : w_grant_idx + 1'b1;
            end
        end
    end

    // Read-modify-write pipeline advance.
    // NOTE: datapath registers are reset too, because they drive RAM address/data outputs that must read 0 in reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_addr    <= '0;
            r_s1_val     <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_addr    <= '0;
            r_s2_val     <= '0;
            r_wr_valid   <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_hold_valid <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_data  <= '0;
        end else begin
            r_s1_valid   <= w_accept;
            r_s1_addr    <= w_accept ? w_sel_addr : r_s1_addr;
            r_s1_val     <= w_accept ? w_sel_val  : r_s1_val;
            r_s2_valid   <= r_s1_valid;
            r_s2_addr    <= r_s1_addr;
            r_s2_val     <= r_s1_val;
            r_wr_valid   <= r_s2_valid;
            r_wr_addr    <= r_s2_valid ? r_s2_addr : r_wr_addr;
            r_wr_data    <= r_s2_valid ? w_result  : r_wr_data;
            r_hold_valid <= r_wr_valid;
            r_hold_addr  <= r_wr_addr;
            r_hold_data  <= r_wr_data;
        end
    end

    assign o_im_rd_en   = r_s1_valid && r_mode;
    assign o_im_rd_addr = r_s1_addr;
    assign o_im_wr_en   = r_wr_valid;
    assign o_im_wr_addr = r_wr_addr;
    assign o_im_wr_data = r_wr_data;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;
    assign o_sat        = r_sat;

endmodule
